ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard.

---
 rtl/ps2_host_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain output enables and an interrupt handshake.
// Optional feature: define PS2_TX_RETRY_EN to retry a failed byte up to two more times before reporting tx_error.
module ps2_host_tx #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int INHIBIT_CYC = CLK_HZ / 100_000 * 12,
  parameter int TIMEOUT_CYC = CLK_HZ / 1_000 * 15,
  parameter int FILTER_LEN  = 8
) (
  input  logic       CLK_Nexys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       interrupt_paro,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       interrupt
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL, DONE, ERR} state_t;

  state_t              state, state_n;
  logic [1:0]          clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                clk_filt, clk_filt_d, fall, data_s;
  logic [7:0]          data_q, data_n;
  logic [9:0]          shift, shift_n;
  logic [3:0]          bit_cnt, bit_cnt_n;
  logic [IW-1:0]       inh_cnt, inh_cnt_n;
  logic [TW-1:0]       to_cnt, to_cnt_n;
  logic                clk_oe_n, data_oe_n, busy_n, done_n, err_n, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]          retry, retry_n;
`endif

  assign data_s = data_sync[1];
  assign fall   = clk_filt_d & ~clk_filt;

  // Synchronizers and clock glitch filter: the filtered level only moves after FILTER_LEN agreeing samples.
  always_ff @(posedge CLK_Nexys or posedge reset) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_hist   <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      clk_filt_d <= clk_filt;
      if (&clk_hist)
        clk_filt <= 1'b1;
      else if (~|clk_hist)
        clk_filt <= 1'b0;
    end
  end

  always_ff @(posedge CLK_Nexys or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      data_q      <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      interrupt   <= 1'b0;
    end else begin
      state       <= state_n;
      data_q      <= data_n;
      shift       <= shift_n;
      bit_cnt     <= bit_cnt_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_error    <= err_n;
      // Acknowledge wins over a simultaneous new completion.
      if (interrupt_paro)
        interrupt <= 1'b0;
      else if (state == DONE || state == ERR)
        interrupt <= 1'b1;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge CLK_Nexys or posedge reset) begin
    if (reset)
      retry <= '0;
    else
      retry <= retry_n;
  end
`endif

  always_comb begin
    state_n   = state;
    data_n    = data_q;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry;
`endif

    if (state == SEND || state == ACK || state == WAIT_REL) begin
      to_cnt_n = fall ? '0 : to_cnt + 1'b1;
      if (!fall && to_cnt == TO_LAST)
        fail = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tx_start) begin
          data_n    = tx_data;
          busy_n    = 1'b1;
          clk_oe_n  = 1'b1;
          inh_cnt_n = '0;
`ifdef PS2_TX_RETRY_EN
          retry_n   = '0;
`endif
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = REQ;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end
      REQ: begin
        clk_oe_n  = 1'b0;
        bit_cnt_n = '0;
        to_cnt_n  = '0;
        shift_n   = {1'b1, ~^data_q, data_q};
        state_n   = SEND;
      end
      SEND: begin
        // Device falls 1..10 each expose the next frame bit; fall 10 puts out the stop bit.
        if (fall) begin
          data_oe_n = ~shift[0];
          shift_n   = {1'b0, shift[9:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'd9)
            state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (data_s)
            fail = 1'b1;
          else
            state_n = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (clk_filt && data_s)
          state_n = DONE;
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ERR: begin
        err_n     = 1'b1;
        busy_n    = 1'b0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      state_n   = ERR;
`ifdef PS2_TX_RETRY_EN
      if (retry < 2'd2) begin
        retry_n   = retry + 1'b1;
        clk_oe_n  = 1'b1;
        inh_cnt_n = '0;
        state_n   = INHIBIT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: an open-drain PS/2 device model clocks frames, a monitor checks each completion.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 50;
  localparam int TIMEOUT_CYC = 2000;
  localparam int FILTER_LEN  = 8;
  localparam int HALF        = 100;
  localparam int MODE_ACK    = 0;
  localparam int MODE_NACK   = 1;
  localparam int MODE_SILENT = 2;
`ifdef PS2_TX_RETRY_EN
  localparam int FAIL_ATTEMPTS = 3;
`else
  localparam int FAIL_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       interrupt_paro = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, interrupt;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ(100_000_000), .INHIBIT_CYC(INHIBIT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .CLK_Nexys(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .interrupt_paro(interrupt_paro), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error), .interrupt(interrupt)
  );

  typedef struct {
    bit         is_err;
    logic [9:0] frame;
    int         frames;
    int         inhibits;
    bit         silent;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         fails = 0;
  int         dev_mode = MODE_ACK;
  int         dev_fall_cnt = 0;
  int         frame_cnt = 0;
  int         inh_cnt = 0;
  logic [9:0] last_frame = '0;
  bit         aborted = 0;
  longint     cycle = 0;
  longint     req_cycle = 0;

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(string name, longint actual, longint lo, longint hi);
    checks++;
    if (actual < lo || actual > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Reference frame as the device sees it on the line: d0..d7, odd parity, stop.
  function automatic logic [9:0] refFrame(logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic hold(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset) aborted = 1;
    end
  endtask

  task automatic runFrame();
    logic [9:0] bits = '0;
    aborted = 0;
    for (int k = 1; k <= 11; k++) begin
      hold(HALF);
      if (aborted) break;
      dev_clk_low  = 1'b1;
      dev_fall_cnt = k;
      if (k == 11) begin
        last_frame = bits;
        frame_cnt++;
      end
      hold(HALF);
      if (aborted) break;
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = data_line;
      if (k == 10 && dev_mode == MODE_ACK) dev_data_low = 1'b1;
    end
    if (!aborted && dev_mode == MODE_ACK) hold(HALF);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_fall_cnt = 0;
  endtask

  // Device: starts clocking once the host has released the clock while holding the start bit.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && !ps2_clk_oe && ps2_data_oe && dev_mode != MODE_SILENT) runFrame();
    end
  end

  // Monitor: pops one expectation per done/error pulse.
  initial begin
    exp_t e;
    int   base_inh = 0;
    int   base_frames = 0;
    logic prev_clk_oe = 1'b0;
    forever begin
      @(negedge clk);
      cycle++;
      if (ps2_clk_oe && !prev_clk_oe) inh_cnt++;
      if (!ps2_clk_oe && prev_clk_oe && ps2_data_oe) req_cycle = cycle;
      prev_clk_oe = ps2_clk_oe;
      if (reset) begin
        base_inh    = inh_cnt;
        base_frames = frame_cnt;
      end else if (tx_done || tx_error) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_pulse: got done=%0b error=%0b, expected none", tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind_error", tx_error, e.is_err);
          checkOutput("pulse_kind_done", tx_done, !e.is_err);
          checkOutput("interrupt_set", interrupt, 1);
          checkOutput("busy_released", tx_busy, 0);
          checkOutput("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
          checkOutput("inhibit_phases", inh_cnt - base_inh, e.inhibits);
          checkOutput("frames_clocked", frame_cnt - base_frames, e.frames);
          if (!e.is_err) checkOutput("frame_bits", last_frame, e.frame);
          if (e.silent) checkRange("timeout_latency", cycle - req_cycle, TIMEOUT_CYC, TIMEOUT_CYC + 10);
        end
        base_inh    = inh_cnt;
        base_frames = frame_cnt;
      end
    end
  end

  task automatic startByte(logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checkOutput("busy_after_start", tx_busy, 1);
  endtask

  task automatic applyStimulus(logic [7:0] d, int mode);
    exp_t e;
    int   attempts;
    dev_mode   = mode;
    attempts   = (mode == MODE_ACK) ? 1 : FAIL_ATTEMPTS;
    e.is_err   = (mode != MODE_ACK);
    e.frame    = refFrame(d);
    e.inhibits = attempts;
    e.frames   = (mode == MODE_SILENT) ? 0 : attempts;
    e.silent   = (mode == MODE_SILENT);
    exp_q.push_back(e);
    startByte(d);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      fails++;
      $display("[TB] FAIL completion_timeout: got busy=%0b pending=%0d, expected idle", tx_busy, exp_q.size());
      exp_q.delete();
    end
    repeat (300) @(negedge clk);
  endtask

  task automatic clearIrq();
    @(negedge clk);
    checkOutput("interrupt_held", interrupt, 1);
    interrupt_paro = 1'b1;
    @(negedge clk);
    interrupt_paro = 1'b0;
    checkOutput("interrupt_cleared", interrupt, 0);
  endtask

  initial begin
    int n;
    $display("[TB] Starting ps2_host_tx bench");
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error, interrupt}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    applyStimulus(8'hED, MODE_ACK);
    waitIdle();
    clearIrq();
    applyStimulus(8'h02, MODE_ACK);
    waitIdle();
    applyStimulus(8'hFF, MODE_ACK);
    waitIdle();
    applyStimulus(8'h00, MODE_ACK);
    waitIdle();
    clearIrq();

    applyStimulus(8'hF4, MODE_SILENT);
    waitIdle();
    clearIrq();

    applyStimulus(8'hED, MODE_NACK);
    waitIdle();
    clearIrq();

    // Abort mid-frame with reset, then a clean transfer.
    dev_mode = MODE_ACK;
    startByte(8'h3C);
    n = 0;
    while (dev_fall_cnt != 4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_fall_4", dev_fall_cnt, 4);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_release", {ps2_clk_oe, ps2_data_oe, tx_busy}, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (400) @(negedge clk);
    applyStimulus(8'hF4, MODE_ACK);
    waitIdle();
    clearIrq();

    // A second start while busy must be ignored.
    applyStimulus(8'hED, MODE_ACK);
    repeat (300) @(negedge clk);
    checkOutput("busy_mid_frame", tx_busy, 1);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    waitIdle();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), MODE_ACK);
      waitIdle();
    end
    clearIrq();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
